// File: rtl/spi_byte_master_pkg.sv
// Shared types and constants for spi_byte_master.
// SPI_MISO_SYNC_EN selects the synchronized, late-sampled MISO path.
package spi_byte_master_pkg;

  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } spi_state_t;

`ifdef SPI_MISO_SYNC_EN
  localparam bit MISO_SYNC_EN = 1'b1;
`else
  localparam bit MISO_SYNC_EN = 1'b0;
`endif

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte handshake between the command processor (master) and spi_byte_master (slave).
interface spi_byte_master_if;
  import spi_byte_master_pkg::*;

  logic [SPI_BITS-1:0] spitx;
  logic                spitxdv;
  logic                spitxready;
  logic [SPI_BITS-1:0] spirx;
  logic                spirxdv;

  modport master (output spitx, spitxdv, input spitxready, spirx, spirxdv);
  modport slave  (input spitx, spitxdv, output spitxready, spirx, spirxdv);

endinterface

// File: rtl/spi_byte_master_miso_sync.sv
// Two-flop MISO synchronizer, built only when SPI_MISO_SYNC_EN is defined.
`ifdef SPI_MISO_SYNC_EN
module miso_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule
`endif

// File: rtl/spi_byte_master.sv
// Byte-wide SPI mode-0 master, MSB first, one byte per spitxdv with a spirxdv pulse back.
// Define SPI_MISO_SYNC_EN for a synchronized MISO path (requires CLKS_PER_HALF_BIT >= 3).
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_byte_master_if.slave bus,
  output logic            spi_sclk,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int CW = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam logic [CW-1:0]        HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_DONE = BIT_CNT_W'(SPI_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SPI_BITS - 1);

  spi_state_t           state, state_nxt;
  logic [CW-1:0]        half_cnt, half_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
  logic [SPI_BITS-1:0]  tx_shift, tx_nxt, rx_shift, rx_nxt, rx_byte, rx_byte_nxt;
  logic                 sclk_q, sclk_nxt, mosi_q, mosi_nxt;
  logic                 ready_q, ready_nxt, rxdv_q, rxdv_nxt;
  logic                 miso_s, half_last, sample_rise, sample_late, sample;

`ifdef SPI_MISO_SYNC_EN
  if (CLKS_PER_HALF_BIT < 3) begin : g_bad_half_bit
    $error("CLKS_PER_HALF_BIT must be >= 3 when SPI_MISO_SYNC_EN is defined");
  end
  miso_sync u_miso_sync (.clk(clk), .rst(rst), .din(spi_miso), .dout(miso_s));
`else
  assign miso_s = spi_miso;
`endif

  assign half_last   = (half_cnt == HALF_LAST);
  assign sample_rise = half_last && ((state == LEAD) || (state == LOW && bit_cnt != BITS_DONE));
  // The synchronizer delays MISO by two clocks, so sampling at the end of HIGH
  // sees the same bit the direct path captures on the SCLK rise.
  assign sample_late = half_last && (state == HIGH);
  assign sample      = MISO_SYNC_EN ? sample_late : sample_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ready_q  <= 1'b1;
      rxdv_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      half_cnt <= half_nxt;
      bit_cnt  <= bit_nxt;
      tx_shift <= tx_nxt;
      rx_shift <= rx_nxt;
      rx_byte  <= rx_byte_nxt;
      sclk_q   <= sclk_nxt;
      mosi_q   <= mosi_nxt;
      ready_q  <= ready_nxt;
      rxdv_q   <= rxdv_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    half_nxt    = (state == IDLE || half_last) ? '0 : half_cnt + CW'(1);
    bit_nxt     = bit_cnt;
    tx_nxt      = tx_shift;
    rx_nxt      = sample ? {rx_shift[SPI_BITS-2:0], miso_s} : rx_shift;
    rx_byte_nxt = rx_byte;
    sclk_nxt    = sclk_q;
    mosi_nxt    = mosi_q;
    ready_nxt   = ready_q;
    rxdv_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.spitxdv) begin
          state_nxt = LEAD;
          tx_nxt    = bus.spitx;
          mosi_nxt  = bus.spitx[SPI_BITS-1];
          ready_nxt = 1'b0;
          bit_nxt   = '0;
        end
      end
      LEAD: begin
        if (half_last) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (half_last) begin
          state_nxt = LOW;
          sclk_nxt  = 1'b0;
          bit_nxt   = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt != LAST_BIT) begin
            tx_nxt   = tx_shift << 1;
            mosi_nxt = tx_shift[SPI_BITS-2];
          end
        end
      end
      LOW: begin
        // After the last fall a full low half-period is held before completing.
        if (half_last) begin
          if (bit_cnt == BITS_DONE) begin
            state_nxt   = IDLE;
            rx_byte_nxt = rx_shift;
            rxdv_nxt    = 1'b1;
            ready_nxt   = 1'b1;
            mosi_nxt    = 1'b0;
          end else begin
            state_nxt = HIGH;
            sclk_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign spi_sclk       = sclk_q;
  assign spi_mosi       = mosi_q;
  assign bus.spitxready = ready_q;
  assign bus.spirx      = rx_byte;
  assign bus.spirxdv    = rxdv_q;

endmodule
